stream_accumulator: RTL and testbench

//   Sequential front end for the 16-bit ripple-carry adder. Sums a block of COUNT

---
 rtl/stream_accumulator.sv | 91 +++++++++
 tb/tb_stream_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_accumulator.sv
// stream_accumulator: sums blocks of COUNT unsigned 16-bit words from a valid/ready
// stream through a ripple-carry adder and presents each block total with a sticky
// overflow flag on a valid/ready output.
module stream_accumulator #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [15:0] sum,
  output logic        sum_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StHold
  } state_e;

  state_e             state_q;
  logic [15:0]        acc_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [15:0]        add_out;
  logic [16:0]        carry;
  logic               add_ovf;
  logic               handshake;

  // Ripple-carry adder: in1 = accumulator, in2 = incoming word.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < 16; i++) begin : g_rca
    assign add_out[i]   = acc_q[i] ^ in_data[i] ^ carry[i];
    assign carry[i+1]   = (acc_q[i] & in_data[i]) | (carry[i] & (acc_q[i] ^ in_data[i]));
  end
  assign add_ovf = carry[16];

  // Outputs are decoded from registered state only.
  assign in_ready     = (state_q != StHold);
  assign sum_valid    = (state_q == StHold);
  assign busy         = (state_q != StIdle);
  assign sum          = acc_q;
  assign sum_overflow = ovf_q;

  assign handshake = in_valid & in_ready;

  // Block FSM with accumulator, sticky overflow and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            acc_q   <= in_data;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_W'(1);
            state_q <= (COUNT == 1) ? StHold : StAcc;
          end
        end
        StAcc: begin
          if (handshake) begin
            acc_q   <= add_out;
            ovf_q   <= ovf_q | add_ovf;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(COUNT - 1)) begin
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          // acc and ovf are kept so the last result stays visible until the next block.
          if (sum_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed self-checking bench for stream_accumulator (COUNT=4 and COUNT=1 instances).
module tb_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        v, r, v1, r1;
  logic [15:0] d, d1;

  logic        in_ready, sum_valid, sum_overflow, busy;
  logic [15:0] sum;
  logic        in_ready1, sum_valid1, sum_overflow1, busy1;
  logic [15:0] sum1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_accumulator #(.COUNT(4), .CNT_W(8)) u_dut4 (
    .clk          (clk),
    .reset        (rst),
    .in_valid     (v),
    .in_ready     (in_ready),
    .in_data      (d),
    .sum_valid    (sum_valid),
    .sum_ready    (r),
    .sum          (sum),
    .sum_overflow (sum_overflow),
    .busy         (busy)
  );

  stream_accumulator #(.COUNT(1), .CNT_W(8)) u_dut1 (
    .clk          (clk),
    .reset        (rst),
    .in_valid     (v1),
    .in_ready     (in_ready1),
    .in_data      (d1),
    .sum_valid    (sum_valid1),
    .sum_ready    (r1),
    .sum          (sum1),
    .sum_overflow (sum_overflow1),
    .busy         (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one word for exactly one rising edge; returns at the following negedge.
  task automatic feed(input logic [15:0] w);
    v = 1'b1;
    d = w;
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; d = '0; r = 1'b1;
    v1 = 1'b0; d1 = '0; r1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", sum_overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(1);

    // 1: back-to-back 1,2,3,4
    feed(16'd1);
    chk("t1_busy_w1", busy, 1);
    feed(16'd2);
    feed(16'd3);
    chk("t1_not_valid_w3", sum_valid, 0);
    feed(16'd4);
    chk("t1_valid", sum_valid, 1);
    chk("t1_sum", sum, 10);
    chk("t1_ovf", sum_overflow, 0);
    chk("t1_in_ready_hold", in_ready, 0);
    idle(1);
    chk("t1_taken_valid", sum_valid, 0);
    chk("t1_taken_busy", busy, 0);

    // 2: overflow, then sticky flag cleared by next block
    feed(16'hFFFF);
    feed(16'h0001);
    feed(16'h0000);
    feed(16'h0000);
    chk("t2_sum", sum, 16'h0000);
    chk("t2_ovf", sum_overflow, 1);
    idle(1);
    chk("t2_kept_ovf_idle", sum_overflow, 1);
    feed(16'd1);
    chk("t2_ovf_cleared_w1", sum_overflow, 0);
    feed(16'd1);
    feed(16'd1);
    feed(16'd1);
    chk("t2b_valid", sum_valid, 1);
    chk("t2b_sum", sum, 4);
    chk("t2b_ovf", sum_overflow, 0);
    idle(1);

    // 3: sparse valid, one word every third cycle
    feed(16'd1);
    idle(2);
    chk("t3_busy_gap", busy, 1);
    chk("t3_acc_w1", sum, 1);
    feed(16'd2);
    idle(2);
    feed(16'd3);
    idle(2);
    chk("t3_not_valid_w3", sum_valid, 0);
    chk("t3_acc_w3", sum, 6);
    feed(16'd4);
    chk("t3_valid", sum_valid, 1);
    chk("t3_sum", sum, 10);
    idle(1);
    chk("t3_busy_after", busy, 0);

    // 4: back-pressure on the result with a word waiting
    r = 1'b0;
    feed(16'd1);
    feed(16'd2);
    feed(16'd3);
    feed(16'd4);
    v = 1'b1;
    d = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", sum_valid, 1);
      chk("t4_hold_sum", sum, 10);
      chk("t4_hold_ready", in_ready, 0);
    end
    r = 1'b1;
    @(negedge clk);
    chk("t4_idle_valid", sum_valid, 0);
    chk("t4_idle_ready", in_ready, 1);
    chk("t4_idle_sum_kept", sum, 10);
    @(negedge clk);
    v = 1'b0;
    chk("t4_seven_busy", busy, 1);
    chk("t4_seven_acc", sum, 7);
    feed(16'd1);
    feed(16'd1);
    feed(16'd1);
    chk("t4b_valid", sum_valid, 1);
    chk("t4b_sum", sum, 10);
    idle(1);

    // 5: reset mid-block, with a concurrent handshake that must lose to reset
    feed(16'd9);
    feed(16'd9);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    v = 1'b1;
    d = 16'd9;
    @(negedge clk);
    rst = 1'b0;
    v = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_valid", sum_valid, 0);
    chk("t5_sum", sum, 0);
    feed(16'd5);
    feed(16'd5);
    feed(16'd5);
    chk("t5_not_valid_w3", sum_valid, 0);
    feed(16'd5);
    chk("t5b_valid", sum_valid, 1);
    chk("t5b_sum", sum, 20);
    idle(1);

    // 6: COUNT=1 instance
    chk("t6_idle_valid", sum_valid1, 0);
    v1 = 1'b1;
    d1 = 16'h1234;
    @(negedge clk);
    v1 = 1'b0;
    chk("t6_valid", sum_valid1, 1);
    chk("t6_sum", sum1, 16'h1234);
    chk("t6_ovf", sum_overflow1, 0);
    @(negedge clk);
    chk("t6_taken", sum_valid1, 0);
    chk("t6_busy", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
